// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one data-memory / I/O port: IDLE -> ACCESS -> (RESP on reads) -> IDLE.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise requester 0 has fixed priority.
module mem_bus_arbiter #(
   parameter logic [31:0] IO_BASE = 32'hFFFF_FFF0,
   parameter logic [31:0] IO_MASK = 32'hFFFF_FFF0,
   localparam int unsigned AW = 32,
   localparam int unsigned DW = 32,
   localparam int unsigned NR = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NR-1:0]    req,
   input  logic [NR-1:0]    we,
   input  logic [NR*AW-1:0] addr,
   input  logic [NR*DW-1:0] wdata,
   output logic [NR-1:0]    gnt,
   output logic [NR-1:0]    rvalid,
   output logic [DW-1:0]    rdata,
   output logic [AW-1:0]    dmem_addr,
   output logic [DW-1:0]    dmem_wdata,
   output logic             dmem_we,
   input  logic [DW-1:0]    dmem_rdata,
   output logic             io_sel,
   input  logic [DW-1:0]    io_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef struct packed {
      logic          win;
      logic          we;
      logic          io;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } xact_t;

   state_e        state_q, state_d;
   xact_t         xact_q, xact_d;
   logic [NR-1:0] gnt_q, gnt_d;
   logic [NR-1:0] rvalid_q, rvalid_d;
   logic          dmem_we_q, dmem_we_d;
   logic          io_sel_q, io_sel_d;
   logic          pick_c;
   logic [AW-1:0] pick_addr_c;
   logic [DW-1:0] pick_wdata_c;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On a tie the requester that did not win last time goes first
   always_comb begin
      if (req == 2'b11) begin
         pick_c = ~last_q;
      end else begin
         pick_c = req[1] & ~req[0];
      end
   end

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && req != '0) begin
         last_d = pick_c;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign pick_c = ~req[0];
`endif

   assign pick_addr_c  = pick_c ? addr[NR*AW-1:AW]  : addr[AW-1:0];
   assign pick_wdata_c = pick_c ? wdata[NR*DW-1:DW] : wdata[DW-1:0];

   // Next state, latched transaction and registered strobes for the following cycle
   always_comb begin
      state_d   = state_q;
      xact_d    = xact_q;
      gnt_d     = '0;
      rvalid_d  = '0;
      dmem_we_d = 1'b0;
      io_sel_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req != '0) begin
               xact_d.win   = pick_c;
               xact_d.we    = we[pick_c];
               xact_d.addr  = pick_addr_c;
               xact_d.wdata = pick_wdata_c;
               xact_d.io    = ((pick_addr_c & IO_MASK) == IO_BASE);
               gnt_d        = pick_c ? 2'b10 : 2'b01;
               dmem_we_d    = xact_d.we & ~xact_d.io;
               io_sel_d     = xact_d.io;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            if (xact_q.we) begin
               state_d = IDLE;
            end else begin
               rvalid_d = xact_q.win ? 2'b10 : 2'b01;
               io_sel_d = xact_q.io;
               state_d  = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         xact_q    <= '0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         dmem_we_q <= 1'b0;
         io_sel_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         xact_q    <= xact_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         dmem_we_q <= dmem_we_d;
         io_sel_q  <= io_sel_d;
      end
   end

   assign gnt        = gnt_q;
   assign rvalid     = rvalid_q;
   assign dmem_we    = dmem_we_q;
   assign io_sel     = io_sel_q;
   assign dmem_addr  = xact_q.addr;
   assign dmem_wdata = xact_q.wdata;

   // Read data passes straight through during RESP; the memory is already one cycle past the address
   assign rdata = (state_q == RESP) ? (xact_q.io ? io_rdata : dmem_rdata) : '0;

`ifndef SYNTHESIS
   a_gnt_onehot0:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
   a_rvalid_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rvalid_q));
   a_no_overlap:     assert property (@(posedge clk) disable iff (!reset_n) !(|gnt_q && |rvalid_q));
   a_we_needs_gnt:   assert property (@(posedge clk) disable iff (!reset_n) dmem_we_q |-> |gnt_q);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with a transaction-scheduling reference model.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req = '0;
   logic [1:0]  we = '0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata, dmem_addr, dmem_wdata, dmem_rdata = '0, io_rdata = '0;
   logic        dmem_we, io_sel;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
      .io_sel(io_sel), .io_rdata(io_rdata)
   );

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: each grant books its output cycles and the next cycle the arbiter may evaluate
   int          cyc = 0;
   int          next_eval, g_cycle, r_cycle, last_win, m_win;
   bit          m_we, m_io;
   logic [31:0] cur_addr, cur_wdata;
   bit   [1:0]  pend = '0;
   logic [1:0]  seq [4];
   int          ng;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit is_io(input logic [31:0] a);
      return (a & 32'hFFFF_FFF0) == 32'hFFFF_FFF0;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 32'h0000_0010;
         1:       return 32'($urandom);
         2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         default: return 32'hFFFF_FFE0 | 32'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic model_reset();
      g_cycle   = -1;
      r_cycle   = -1;
      next_eval = 0;
      last_win  = 1;
      m_win     = 0;
      m_we      = 1'b0;
      m_io      = 1'b0;
      cur_addr  = '0;
      cur_wdata = '0;
   endtask

   // One clock: model evaluates at the edge, DUT outputs compared 1 time unit later
   task automatic step();
      int          w;
      logic [31:0] a;
      logic [1:0]  exp_g, exp_rv;
      logic [31:0] exp_rd;
      bit          exp_we, exp_io;
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
         model_reset();
      end else if (cyc >= next_eval && req != 2'b00) begin
         if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = 1 - last_win;
`else
            w = 0;
`endif
         end else begin
            w = req[1] ? 1 : 0;
         end
         last_win  = w;
         m_win     = w;
         m_we      = we[w];
         a         = addr[32*w +: 32];
         m_io      = is_io(a);
         cur_addr  = a;
         cur_wdata = wdata[32*w +: 32];
         g_cycle   = cyc;
         r_cycle   = m_we ? -1 : cyc + 1;
         next_eval = cyc + (m_we ? 2 : 3);
      end
      #1;
      exp_g  = (g_cycle == cyc) ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_rv = (r_cycle == cyc) ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_we = (g_cycle == cyc) && m_we && !m_io;
      exp_io = m_io && (g_cycle == cyc || r_cycle == cyc);
      exp_rd = (r_cycle == cyc) ? (m_io ? io_rdata : dmem_rdata) : 32'h0;
      check("gnt",        64'(gnt),        64'(exp_g));
      check("rvalid",     64'(rvalid),     64'(exp_rv));
      check("dmem_we",    64'(dmem_we),    64'(exp_we));
      check("io_sel",     64'(io_sel),     64'(exp_io));
      check("rdata",      64'(rdata),      64'(exp_rd));
      check("dmem_addr",  64'(dmem_addr),  64'(cur_addr));
      check("dmem_wdata", 64'(dmem_wdata), 64'(cur_wdata));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      we      = '0;
      addr    = '0;
      wdata   = '0;
      pend    = '0;
      model_reset();
      repeat (2) step();
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      check("rst_gnt", 64'(gnt), 64'(2'b00));

      // Single write from requester 0
      req = 2'b01; we = 2'b01; addr = {32'h0, 32'h10}; wdata = {32'h0, 32'hDEAD_BEEF};
      step();
      check("wr_gnt", 64'(gnt), 64'(2'b01));
      check("wr_we", 64'(dmem_we), 64'(1'b1));
      check("wr_addr", 64'(dmem_addr), 64'(32'h10));
      check("wr_io", 64'(io_sel), 64'(1'b0));
      req = 2'b00;
      step();
      check("wr_idle_we", 64'(dmem_we), 64'(1'b0));

      // Memory read from requester 1
      req = 2'b10; we = 2'b00; addr = {32'h10, 32'h0};
      step();
      check("rd1_gnt", 64'(gnt), 64'(2'b10));
      req = 2'b00; dmem_rdata = 32'hDEAD_BEEF;
      step();
      check("rd1_rvalid", 64'(rvalid), 64'(2'b10));
      check("rd1_rdata", 64'(rdata), 64'(32'hDEAD_BEEF));
      step();

      // I/O window read from requester 0
      req = 2'b01; we = 2'b00; addr = {32'h0, 32'hFFFF_FFF4}; io_rdata = 32'h0000_1234;
      step();
      check("io_sel_acc", 64'(io_sel), 64'(1'b1));
      check("io_we", 64'(dmem_we), 64'(1'b0));
      req = 2'b00;
      step();
      check("io_sel_resp", 64'(io_sel), 64'(1'b1));
      check("io_rdata", 64'(rdata), 64'(32'h1234));
      step();

      // Both requesters held continuously
      do_reset();
      req = 2'b11; we = 2'b11; addr = {32'h20, 32'h10}; wdata = {32'h2, 32'h1};
      ng = 0;
      for (int k = 0; k < 4; k++) seq[k] = '0;
      for (int t = 0; t < 8; t++) begin
         step();
         if (gnt != 2'b00 && ng < 4) begin
            seq[ng] = gnt;
            ng++;
         end
      end
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         check("tie_seq", 64'(seq[k]), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
`else
         check("tie_seq", 64'(seq[k]), 64'(2'b01));
`endif
      end

      // Reset asserted in the middle of a write ACCESS
      do_reset();
      req = 2'b01; we = 2'b01; addr = {32'h0, 32'h40}; wdata = {32'h0, 32'h55};
      step();
      check("abort_we_before", 64'(dmem_we), 64'(1'b1));
      req = 2'b00;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("abort_we_async", 64'(dmem_we), 64'(1'b0));
      check("abort_gnt_async", 64'(gnt), 64'(2'b00));
      check("abort_addr_async", 64'(dmem_addr), 64'(32'h0));
      step();
      @(negedge clk) reset_n = 1'b1;
      repeat (4) begin
         step();
         check("abort_no_gnt", 64'(gnt), 64'(2'b00));
         check("abort_no_rvalid", 64'(rvalid), 64'(2'b00));
      end

      // Randomized traffic with withdrawals and occasional resets
      for (int t = 0; t < 3000; t++) begin
         if (t % 700 == 699) do_reset();
         for (int i = 0; i < 2; i++) begin
            bit granted;
            granted = (g_cycle == cyc) && (m_win == i);
            if (pend[i] && !granted) begin
               if ($urandom_range(0, 15) == 0) begin
                  pend[i] = 1'b0;
                  req[i]  = 1'b0;
               end
            end else if ($urandom_range(0, 1) == 1) begin
               pend[i]            = 1'b1;
               req[i]             = 1'b1;
               we[i]              = 1'($urandom_range(0, 1));
               addr[32*i +: 32]   = rand_addr();
               wdata[32*i +: 32]  = 32'($urandom);
            end else begin
               pend[i] = 1'b0;
               req[i]  = 1'b0;
            end
         end
         dmem_rdata = 32'($urandom);
         io_rdata   = 32'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter IO_BASE, default 32'hFFFF_FFF0; base address of the I/O window.
REQ-002 Parameter IO_MASK, default 32'hFFFF_FFF0; address is I/O when (addr & IO_MASK) == IO_BASE, otherwise data memory.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  2  per-requester access request; bit0 = requester 0 (CPU), bit1 = requester 1.
REQ-006 we  in  2  per-requester write enable: 1 = write, 0 = read.
REQ-007 addr  in  64  packed addresses {addr1[31:0], addr0[31:0]}.
REQ-008 wdata  in  64  packed write data {wdata1, wdata0}.
REQ-009 gnt  out  2  one-cycle grant pulse, one-hot or zero.
REQ-010 rvalid  out  2  one-cycle read-data-valid pulse, one-hot or zero.
REQ-011 rdata  out  32  read data; meaningful only while any rvalid bit is high, 0 otherwise.
REQ-012 dmem_addr  out  32  data memory / I/O address.
REQ-013 dmem_wdata  out  32  write data to data memory and I/O.
REQ-014 dmem_we  out  1  data memory write strobe.
REQ-015 dmem_rdata  in  32  synchronous-read data memory output, valid one cycle after the address.
REQ-016 io_sel  out  1  I/O window select; equivalent of the CPU io_rw flag.
REQ-017 io_rdata  in  32  I/O buffer read data.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; exactly one state is active at any time.
REQ-019 IDLE: at a clock edge with req != 0, latch the winner index, its we, addr and wdata, and the I/O decode flag, then enter ACCESS; with req == 0, remain in IDLE.
REQ-020 ACCESS lasts exactly one cycle: gnt[winner] = 1; dmem_we = latched we AND NOT io flag; io_sel = io flag.
REQ-021 ACCESS exit: a write returns to IDLE; a read enters RESP.
REQ-022 RESP lasts exactly one cycle: rvalid[winner] = 1; io_sel holds the io flag; rdata = io flag ? io_rdata : dmem_rdata; the next state is IDLE.
REQ-023 Latency: req sampled at edge k; gnt high in cycle k+1; read rvalid high in cycle k+2; the earliest next grant is in cycle k+2 for a write and k+3 for a read.
REQ-024 dmem_addr and dmem_wdata always drive the latched registers; dmem_we = 0 and io_sel = 0 in IDLE.
REQ-025 A requester holds req, we, addr and wdata stable until its gnt.
REQ-026 Dropping req while in IDLE withdraws the request with no side effect.
REQ-027 A req still high in the cycle after gnt is a new request.
REQ-028 Requests arriving during ACCESS or RESP are ignored and are re-evaluated on return to IDLE.
REQ-029 Simultaneous req = 2'b11 resolves per REQ-035/036; the loser is served in its next IDLE evaluation if it is still requesting.
REQ-030 I/O decode is computed once from the winning address at latch time.

Reset
REQ-031 reset_n low asynchronously forces state = IDLE and gnt = rvalid = 0.
REQ-032 reset_n low also forces dmem_we = io_sel = 0; latched addr, wdata, we and the io flag = 0; last_winner = 1.
REQ-033 Reset in ACCESS or RESP aborts the transaction: no write strobe, no rvalid after release.
REQ-034 The first evaluation after release occurs at the first rising edge with reset_n high.

Configuration
REQ-035 With ARB_ROUND_ROBIN_EN defined, a last_winner register updates on every grant; on req = 2'b11 the requester != last_winner wins; reset makes requester 0 win first.
REQ-036 Without ARB_ROUND_ROBIN_EN, requester 0 has fixed priority on req = 2'b11 and the last_winner register is not implemented.

Verification
REQ-037 Reset, then req = 2'b01, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF -> next cycle gnt = 01, dmem_we = 1, dmem_addr = 0x10, io_sel = 0; following cycle IDLE, dmem_we = 0.
REQ-038 req = 2'b10 read at addr1 = 0x10, with dmem_rdata = 0xDEADBEEF in RESP -> gnt = 10 at k+1, rvalid = 10 and rdata = 0xDEADBEEF at k+2.
REQ-039 Read at addr0 = 0xFFFF_FFF4 with io_rdata = 0x0000_1234 -> io_sel = 1 in ACCESS and RESP, dmem_we = 0, rdata = 0x1234.
REQ-040 req = 2'b11 held continuously with round-robin enabled -> grants 01, 10, 01, 10; round-robin disabled -> 01 on every grant.
REQ-041 reset_n low during ACCESS of a write -> dmem_we falls immediately; after release no gnt or rvalid appears until a new req.
